// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter sharing one single-port variable-latency memory
// Optional fetch starvation guard enabled by defining FETCH_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              rclk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              owner_d
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            r_state;
  logic              r_owner_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;

  logic w_any_req;
  logic w_force_f;
  logic w_grant_d;

`ifdef FETCH_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] r_starve;

  assign w_force_f = (r_starve == CW'(STARVE_MAX));

  // Counts data grants that overtook a waiting fetch.
  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (r_state == S_IDLE && w_any_req) begin
      if (!if_req || !w_grant_d)
        r_starve <= '0;
      else if (r_starve != CW'(STARVE_MAX))
        r_starve <= r_starve + 1'b1;
    end
  end
`else
  assign w_force_f = 1'b0;
`endif

  assign w_any_req = if_req | d_req;
  assign w_grant_d = d_req & ~(if_req & w_force_f);

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner_d  <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_d <= w_grant_d;
            r_we      <= w_grant_d & d_we;
            r_addr    <= w_grant_d ? {d_addr[ADDR_W-1:2], 2'b00}
                                   : {if_addr[ADDR_W-1:2], 2'b00};
            r_wdata   <= w_grant_d ? d_wdata : 32'd0;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            if (!r_owner_d)
              r_if_rdata <= mem_rdata;
            else if (!r_we)
              r_d_rdata <= mem_rdata;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_en    = (r_state == S_ACCESS);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign owner_d   = r_owner_d;
  assign if_ack    = (r_state == S_DONE) & ~r_owner_d;
  assign d_ack     = (r_state == S_DONE) & r_owner_d;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-port, variable-latency memory between the instruction-fetch path and the load/store path of the RV32I core, replacing the separate instruction and data memories. Each requester holds a level request until it receives a one-cycle acknowledge carrying read data. The memory side has a registered enable/ready handshake. Data accesses have priority over fetch by default.

## Interface
Parameters:
- ADDR_W, 8, byte-address width on all address ports.
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending; used only under the starvation guard.

Ports:
- rclk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; level, held until if_ack.
- if_addr  in  ADDR_W  fetch byte address.
- if_rdata  out  32  fetched word, registered.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; level, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data, registered.
- d_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access valid.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  latched address with bits [1:0] forced to 0.
- mem_wdata  out  32  latched store data.
- mem_rdata  in  32  memory read data; valid when mem_ready=1.
- mem_ready  in  1  access complete; sampled only while mem_en=1.
- busy  out  1  1 in every state except IDLE.
- owner_d  out  1  1 when the current or last grant is data.

## Operation
- FSM states: IDLE, ACCESS, DONE. Owner register: fetch or data.
- IDLE behaviour:
  - No request: stay in IDLE.
  - Otherwise, arbitrate on the current requests.
  - Latch the winner's address, we (0 for fetch) and wdata.
  - Set owner and go to ACCESS.
- Arbitration:
  - Only d_req high: data wins.
  - Only if_req high: fetch wins.
  - Both high: data wins, unless the starvation guard forces fetch.
- ACCESS behaviour:
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latches and stay stable for the whole state.
  - mem_ready=0: stay in ACCESS. There is no timeout.
  - mem_ready=1 on a load or fetch: capture mem_rdata into the owner's rdata register.
  - mem_ready=1 on a store: d_rdata is left unchanged.
  - With mem_ready=1, go to DONE.
- DONE behaviour:
  - The owner's ack is 1 for exactly this cycle. Requests are ignored.
  - Next state is always IDLE.
  - The requester must drop req by the end of the ack cycle. A req still high in the following IDLE cycle is a new request.
- Requester inputs are sampled only in IDLE. Changes during ACCESS or DONE have no effect on the access in flight.
- Reset (rst=0), asynchronous:
  - State goes to IDLE.
  - mem_en, mem_we, if_ack, d_ack, busy and owner_d go to 0.
  - if_rdata, d_rdata, latches and starvation counter go to 0.
  - A store already presented to memory is not rescinded.
  - Operation resumes on the first rising edge with rst=1.

## Timing
- A request first seen in IDLE at cycle 0 gives ACCESS at cycle 1 (mem_en=1).
- With mem_ready=1 in cycle 1: DONE and ack at cycle 2, rdata valid from cycle 2, IDLE at cycle 3.
- Each memory wait cycle adds one cycle.
- Minimum service time is 3 cycles per access, so back-to-back accesses start every 3 cycles.
- All outputs are registered or decoded directly from state; there are no combinational paths from input to output.

## Configuration
- FETCH_STARVE_GUARD_EN, defined:
  - A counter of width $clog2(STARVE_MAX+1) increments on each data grant made while if_req=1.
  - When the counter equals STARVE_MAX and both requests are high, fetch wins.
  - The counter clears on any fetch grant, and on any arbitration where if_req=0.
- FETCH_STARVE_GUARD_EN, undefined:
  - Strict data priority; no counter is built.
  - If d_req never goes low, fetch can starve indefinitely.

## Test plan
- Reset then fetch:
  - Stimulus: rst low 2 cycles then released; if_req=1, if_addr=8'h07; mem_ready=1 and mem_rdata=32'h00500093 from the first mem_en cycle.
  - Response: mem_addr=8'h04 in cycle 1; if_ack and if_rdata=32'h00500093 in cycle 2; busy=0 in cycle 3.
- Store with wait states:
  - Stimulus: d_req=1, d_we=1, d_addr=8'h10, d_wdata=32'hDEADBEEF; mem_ready low for 3 cycles.
  - Response: mem_en=1 and mem_we=1 for 4 cycles with stable mem_addr/mem_wdata; d_ack one cycle later; d_rdata unchanged.
- Simultaneous requests:
  - Stimulus: if_req=1 and d_req=1 in the same cycle; both requesters follow the ack rule.
  - Response: data is served first (owner_d=1), then fetch; there is exactly 1 idle cycle between DONE and the next ACCESS.
- Starvation guard:
  - Stimulus: FETCH_STARVE_GUARD_EN defined, STARVE_MAX=4; d_req and if_req held high continuously.
  - Response: 4 data grants, then 1 fetch grant, repeating.
  - Stimulus: same, with the macro undefined.
  - Response: 0 fetch grants over 50 cycles.
- Reset mid-access:
  - Stimulus: rst=0 asserted during ACCESS with mem_ready=0.
  - Response: mem_en=0 and busy=0 immediately, with no ack pulse; after release, a new request is served normally.
